// File: rtl/i2s_link_sched_pkg.sv
// Shared link states and constants for the I2S frame scheduler.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ACQUIRE,
    LOCKED
  } link_state_t;

  localparam int FRAME_BITS_DEF = 64;

  localparam logic [23:0] TESTPAT_REAL = 24'h123456;
  localparam logic [23:0] TESTPAT_IMAG = 24'habcdef;

endpackage

// File: rtl/i2s_link_sched_if.sv
// Sample sources A/B and the transmit-shifter load port of the I2S link scheduler.
interface i2s_link_sched_if;

  logic        a_valid;
  logic [23:0] a_real;
  logic [23:0] a_imag;
  logic        a_ready;
  logic        b_valid;
  logic [23:0] b_real;
  logic [23:0] b_imag;
  logic        b_ready;
  logic [23:0] tx_real;
  logic [23:0] tx_imag;
  logic        tx_load;

  // master is the scheduler; slave is the sources plus the transmit shifter
  modport master (
    input  a_valid, a_real, a_imag, b_valid, b_real, b_imag,
    output a_ready, b_ready, tx_real, tx_imag, tx_load
  );

  modport slave (
    output a_valid, a_real, a_imag, b_valid, b_real, b_imag,
    input  a_ready, b_ready, tx_real, tx_imag, tx_load
  );

endinterface

// File: rtl/i2s_frame_mon.sv
// LRCLK edge detection and bit counting; flags good frames and framing mismatches.
module i2s_frame_mon #(
  parameter int FRAME_BITS = 64,
  parameter int CNT_W      = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic ws,
  output logic rise,
  output logic good,
  output logic mismatch
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(FRAME_BITS / 2);

  logic             ws_d;
  logic             fall;
  logic             fall_ok;
  logic [CNT_W-1:0] bit_cnt;

  assign rise = ws & ~ws_d;
  assign fall = ~ws & ws_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ws_d    <= 1'b0;
      bit_cnt <= '0;
      fall_ok <= 1'b0;
    end else begin
      ws_d <= ws;
      if (rise)
        bit_cnt <= CNT_W'(1);
      else if (bit_cnt != CNT_MAX)
        bit_cnt <= bit_cnt + CNT_W'(1);
      if (rise)
        fall_ok <= 1'b0;
      else if (fall && (bit_cnt == HALF))
        fall_ok <= 1'b1;
    end
  end

  // Saturation is flagged once, on the cycle the counter is about to pin at its maximum.
  assign good     = rise & fall_ok & (bit_cnt == FULL);
  assign mismatch = (rise & ~good)
                  | (fall & (bit_cnt != HALF))
                  | (~rise & (bit_cnt == CNT_MAX - CNT_W'(1)));

endmodule

// File: rtl/i2s_link_sched.sv
// I2S link scheduler: LRCLK lock FSM plus per-frame round-robin sample arbitration.
// Optional macro I2S_TESTPAT_EN adds a test_mode input that sends a fixed pattern.
module i2s_link_sched
  import i2s_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int LOCK_FRAMES = 4,
  parameter int CNT_W       = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ws,
  input  logic              enable,
  input  logic              err_clr,
`ifdef I2S_TESTPAT_EN
  input  logic              test_mode,
`endif
  i2s_link_sched_if.master  bus,
  output logic              sync,
  output logic              grant,
  output logic              underrun,
  output logic              frame_err
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  link_state_t   state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          rise, good, mismatch;
  logic          arb_fire, set_ferr;
  logic          prefer_b, pick_b, serve;
  logic [23:0]   tx_real_q, tx_imag_q;
  logic          tx_load_q, a_ready_q, b_ready_q;

  i2s_frame_mon #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_mon (
    .clock    (clock),
    .reset    (reset),
    .ws       (ws),
    .rise     (rise),
    .good     (good),
    .mismatch (mismatch)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // The rise that completes lock already arbitrates the first locked frame.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    arb_fire = 1'b0;
    set_ferr = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SEARCH;
          good_d  = '0;
        end
        SEARCH: begin
          if (rise) begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end
        ACQUIRE: begin
          if (good) begin
            if (good_q == GW'(LOCK_FRAMES - 1)) begin
              state_d  = LOCKED;
              good_d   = '0;
              arb_fire = 1'b1;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else if (mismatch) begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            set_ferr = 1'b1;
            state_d  = SEARCH;
          end else if (good) begin
            arb_fire = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sync = (state_q == LOCKED);

  // prefer_b is separate from grant so that after reset A wins a tie even though grant reads 0.
  always_comb begin
    serve  = bus.a_valid | bus.b_valid;
    pick_b = bus.b_valid & (~bus.a_valid | prefer_b);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_real_q <= '0;
      tx_imag_q <= '0;
      tx_load_q <= 1'b0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      grant     <= 1'b0;
      prefer_b  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      underrun  <= underrun & ~err_clr;
      frame_err <= (frame_err & ~err_clr) | set_ferr;
      if (!enable) begin
        tx_real_q <= '0;
        tx_imag_q <= '0;
      end else if (arb_fire) begin
        tx_load_q <= 1'b1;
`ifdef I2S_TESTPAT_EN
        if (test_mode) begin
          tx_real_q <= TESTPAT_REAL;
          tx_imag_q <= TESTPAT_IMAG;
        end else
`endif
        if (serve) begin
          tx_real_q <= pick_b ? bus.b_real : bus.a_real;
          tx_imag_q <= pick_b ? bus.b_imag : bus.a_imag;
          a_ready_q <= ~pick_b;
          b_ready_q <= pick_b;
          grant     <= pick_b;
          prefer_b  <= ~pick_b;
        end else begin
          tx_real_q <= '0;
          tx_imag_q <= '0;
          underrun  <= 1'b1;
        end
      end
    end
  end

  assign bus.tx_real = tx_real_q;
  assign bus.tx_imag = tx_imag_q;
  assign bus.tx_load = tx_load_q;
  assign bus.a_ready = a_ready_q;
  assign bus.b_ready = b_ready_q;

endmodule

// File: doc/i2s_link_sched.md
Name: i2s_link_sched

Overview:
Frame-level controller for the I2S slave link, clocked by BCLK. It locks onto LRCLK framing and raises the sync that gates the I2S receive/transmit shifters. Each locked frame it arbitrates between two 24-bit I/Q sample sources (DDC channel A and B) and hands one sample to the transmit shifter. It also reports lock, underrun and framing errors to the control logic.

Parameters:
FRAME_BITS, 64, BCLK cycles per LRCLK period (both halves)
LOCK_FRAMES, 4, consecutive good frames required to declare lock
CNT_W, 7, width of the bit counter; must satisfy 2^CNT_W > FRAME_BITS+1

Ports:
clock  in  1  BCLK
reset  in  1  asynchronous, active-low reset
ws  in  1  LRCLK, already synchronous to BCLK
enable  in  1  link enable; low forces IDLE
a_valid  in  1  source A has a sample
a_real  in  24  source A I
a_imag  in  24  source A Q
a_ready  out  1  one-cycle pulse: A sample consumed
b_valid  in  1  source B has a sample
b_real  in  24  source B I
b_imag  in  24  source B Q
b_ready  out  1  one-cycle pulse: B sample consumed
tx_real  out  24  sample to the transmit shifter
tx_imag  out  24  sample to the transmit shifter
tx_load  out  1  one-cycle pulse at frame start; tx_* valid from this cycle
sync  out  1  framing lock; high enables the shifters
grant  out  1  0 = A, 1 = B; last-served source
underrun  out  1  sticky: frame passed with no valid source
frame_err  out  1  sticky: framing mismatch
err_clr  in  1  clears underrun and frame_err

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours A; counters 0.
- Edge detection: ws_d registered each cycle. rise = ws & ~ws_d; fall = ~ws & ws_d.
- bit_cnt: counts cycles since the last rise and saturates at 2^CNT_W-1. A rise loads 1.
- Good frame: rise with bit_cnt==FRAME_BITS, and exactly one fall seen at bit_cnt==FRAME_BITS/2.
- Any other rise, a fall at the wrong count, or saturation is a mismatch.
- States:
  - IDLE: sync=0. Goes to SEARCH when enable=1.
  - SEARCH: waits for the first rise, then goes to ACQUIRE with good_cnt=0.
  - ACQUIRE: a good frame increments good_cnt. At LOCK_FRAMES the block enters LOCKED. A mismatch clears good_cnt and stays in ACQUIRE.
  - LOCKED: sync=1. A mismatch sets frame_err, sync=0 next cycle, and returns to SEARCH.
  - Any state: enable=0 goes to IDLE next cycle. tx_* and tx_load are forced to 0; sticky flags are kept.
- Arbitration happens in LOCKED on a good-frame rise, at cycle k:
  - Only one valid: that source wins.
  - Both valid: the source not granted last wins (round robin).
  - Winner's data is registered into tx_* at k+1. tx_load=1 at k+1, winner's ready=1 at k+1, and grant is updated.
  - Sources must hold valid and data stable until ready.
  - No valid: tx_* is set to 0, tx_load=1, underrun set, grant unchanged.
- The first LOCKED frame arbitrates on the rise that completes lock.
- At most one ready pulse per frame; never both.
- err_clr: clears the flags next cycle. A new error in the same cycle wins (flag stays set).
- Asynchronous reset mid-frame: immediate return to reset values. Re-lock takes LOCK_FRAMES+1 rises.

Optional Feature:
I2S_TESTPAT_EN:
- Defined: adds input test_mode (1 bit). When test_mode=1, arbitration is bypassed: tx_real=24'h123456, tx_imag=24'habcdef each frame, no ready pulses, no underrun.
- Undefined: no port and no logic.

Decomposition:
- Package i2s_pkg holds the state enum (IDLE, SEARCH, ACQUIRE, LOCKED), the FRAME_BITS default, and the test-pattern constants.
- One sub-module, i2s_frame_mon: edge detection, bit_cnt, good/mismatch decode. The scheduler instantiates it.

Test Plan:
- Clean 64-bit frames, ws high/low 32 each, enable=1 → sync rises 1 cycle after the 5th rise; frame_err=0.
- Locked, one frame of 62 cycles → frame_err=1, sync=0; re-lock after 5 further good rises.
- Locked, a_valid=b_valid=1 held → grants alternate A,B,A,B; tx_real toggles between a_real=24'h000111 and b_real=24'h000222; one ready per frame.
- Locked, no valid → tx_real=0, tx_load pulses, underrun=1; err_clr → underrun=0 next cycle.
- Assert reset mid-ACQUIRE after 2 good frames → all outputs 0 immediately; lock needs the full 5 rises again.
- With I2S_TESTPAT_EN and test_mode=1 → tx_real=24'h123456, tx_imag=24'habcdef each frame; a_ready stays 0.
